// File: rtl/sdc_seq_counters_if.sv
// ---------------------------------------------------------------------------
// sdc_seq_counters_if
// Signal bundle between the SD-card read state machine (master) and the
// event/sequence counter pair (slave), all on the sdc_clk domain.
//   cnt_en    master->slave : event pulse, one count per high cycle
//   cnt       slave->master : event count
//   cnt_strb  slave->master : high while cnt equals its terminal value
//   seq_en    master->slave : sequence counter clock enable
//   seq_start master->slave : sequence start strobe
//   seq_cnt   slave->master : sequence count
//   seq_busy  slave->master : sequence run in progress
//   seq_strb  slave->master : one-cycle end-of-run strobe
// ---------------------------------------------------------------------------
interface sdc_seq_counters_if #(
  parameter int unsigned CNT_DW = 8,
  parameter int unsigned SEQ_DW = 6
);
  logic              cnt_en;
  logic [CNT_DW-1:0] cnt;
  logic              cnt_strb;
  logic              seq_en;
  logic              seq_start;
  logic [SEQ_DW-1:0] seq_cnt;
  logic              seq_busy;
  logic              seq_strb;

  modport master (
    output cnt_en, seq_en, seq_start,
    input  cnt, cnt_strb, seq_cnt, seq_busy, seq_strb
  );

  modport slave (
    input  cnt_en, seq_en, seq_start,
    output cnt, cnt_strb, seq_cnt, seq_busy, seq_strb
  );
endinterface

// File: rtl/sdc_seq_counters.sv
// ---------------------------------------------------------------------------
// sdc_seq_counters
// Event counter plus fixed-length sequence counter for the SD-card
// single-block read path. Each raises a one-cycle terminal strobe.
// Ports:
//   sdc_clk : clock, rising edge
//   reset   : synchronous, active-high
//   bus     : sdc_seq_counters_if.slave (see interface for signal list)
// Configuration macro:
//   SDC_SEQ_RESTART_EN - when defined, seq_start during a run restarts it
//                        (count back to 1, no strobe for the aborted run);
//                        when undefined, seq_start during a run is ignored.
// ---------------------------------------------------------------------------
module sdc_seq_counters #(
  parameter int unsigned         CNT_DW  = 8,
  parameter logic [CNT_DW-1:0]   CNT_MAX = 8'h40,
  parameter int unsigned         SEQ_DW  = 6,
  parameter logic [SEQ_DW-1:0]   SEQ_MAX = 6'h3E
) (
  input  logic                sdc_clk,
  input  logic                reset,
  sdc_seq_counters_if.slave   bus
);

  localparam logic [CNT_DW-1:0] CNT_ZERO = {CNT_DW{1'b0}};
  localparam logic [CNT_DW-1:0] CNT_ONE  = {{(CNT_DW-1){1'b0}}, 1'b1};
  localparam logic [SEQ_DW-1:0] SEQ_ZERO = {SEQ_DW{1'b0}};
  localparam logic [SEQ_DW-1:0] SEQ_ONE  = {{(SEQ_DW-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } seq_state_t;

  logic [CNT_DW-1:0] cnt_r;
  logic [CNT_DW-1:0] cnt_next_s;
  logic              cnt_strb_r;
  seq_state_t        seq_state_r;
  logic [SEQ_DW-1:0] seq_cnt_r;
  logic              seq_busy_r;
  logic              seq_strb_r;

  // Next event count: the terminal value is never held, it is left after one cycle.
  always_comb begin
    cnt_next_s = cnt_r;
    if (cnt_r == CNT_MAX) begin
      if (bus.cnt_en) begin
        cnt_next_s = CNT_ONE;
      end else begin
        cnt_next_s = CNT_ZERO;
      end
    end else if (bus.cnt_en) begin
      cnt_next_s = cnt_r + CNT_ONE;
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Event counter register; the strobe is loaded from the next count so it
  // lines up exactly with cnt == CNT_MAX.
  always_ff @(posedge sdc_clk) begin
    if (reset) begin
      cnt_r      <= CNT_ZERO;
      cnt_strb_r <= 1'b0;
    end else begin
      cnt_r      <= cnt_next_s;
      cnt_strb_r <= (cnt_next_s == CNT_MAX);
    end
  end

  // Sequence counter FSM; with seq_en low every register, strobe included, holds.
  always_ff @(posedge sdc_clk) begin
    if (reset) begin
      seq_state_r <= S_IDLE;
      seq_cnt_r   <= SEQ_ZERO;
      seq_busy_r  <= 1'b0;
      seq_strb_r  <= 1'b0;
    end else if (bus.seq_en) begin
      case (seq_state_r)
        S_IDLE: begin
          // The strobe cycle is idle, so a start here chains runs without a gap.
          seq_strb_r <= 1'b0;
          if (bus.seq_start) begin
            seq_state_r <= S_BUSY;
            seq_cnt_r   <= SEQ_ONE;
            seq_busy_r  <= 1'b1;
          end else begin
            seq_state_r <= S_IDLE;
            seq_cnt_r   <= SEQ_ZERO;
            seq_busy_r  <= 1'b0;
          end
        end
        S_BUSY: begin
`ifdef SDC_SEQ_RESTART_EN
          if (bus.seq_start) begin
            seq_state_r <= S_BUSY;
            seq_cnt_r   <= SEQ_ONE;
            seq_busy_r  <= 1'b1;
            seq_strb_r  <= 1'b0;
          end else
`endif
          if (seq_cnt_r == SEQ_MAX) begin
            seq_state_r <= S_IDLE;
            seq_cnt_r   <= SEQ_ZERO;
            seq_busy_r  <= 1'b0;
            seq_strb_r  <= 1'b1;
          end else begin
            seq_state_r <= S_BUSY;
            seq_cnt_r   <= seq_cnt_r + SEQ_ONE;
            seq_busy_r  <= 1'b1;
            seq_strb_r  <= 1'b0;
          end
        end
        default: begin
          seq_state_r <= S_IDLE;
          seq_cnt_r   <= SEQ_ZERO;
          seq_busy_r  <= 1'b0;
          seq_strb_r  <= 1'b0;
        end
      endcase
    end else begin
      seq_state_r <= seq_state_r;
      seq_cnt_r   <= seq_cnt_r;
      seq_busy_r  <= seq_busy_r;
      seq_strb_r  <= seq_strb_r;
    end
  end

  assign bus.cnt      = cnt_r;
  assign bus.cnt_strb = cnt_strb_r;
  assign bus.seq_cnt  = seq_cnt_r;
  assign bus.seq_busy = seq_busy_r;
  assign bus.seq_strb = seq_strb_r;

endmodule

// File: tb/tb_sdc_seq_counters.sv
// ---------------------------------------------------------------------------
// tb_sdc_seq_counters
// Directed self-checking bench for sdc_seq_counters (CNT_MAX = 0x40,
// SEQ_MAX = 0x3E). Inputs change and outputs are sampled on the falling
// edge of sdc_clk. Expected strobe timing depends on SDC_SEQ_RESTART_EN.
// ---------------------------------------------------------------------------
module tb_sdc_seq_counters;
  logic sdc_clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  sdc_seq_counters_if #(.CNT_DW(8), .SEQ_DW(6)) bus ();

  sdc_seq_counters #(
    .CNT_DW (8),
    .CNT_MAX(8'h40),
    .SEQ_DW (6),
    .SEQ_MAX(6'h3E)
  ) dut (
    .sdc_clk(sdc_clk),
    .reset  (reset),
    .bus    (bus)
  );

  initial sdc_clk = 1'b0;
  always #5 sdc_clk = ~sdc_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".cnt"},      32'(bus.cnt),      32'd0);
    chk({tag, ".cnt_strb"}, 32'(bus.cnt_strb), 32'd0);
    chk({tag, ".seq_cnt"},  32'(bus.seq_cnt),  32'd0);
    chk({tag, ".seq_busy"}, 32'(bus.seq_busy), 32'd0);
    chk({tag, ".seq_strb"}, 32'(bus.seq_strb), 32'd0);
  endtask

  initial begin
    int strb_n;
    int strb_t[4];
    int first_t;
    n_cmp = 0;
    n_err = 0;

    // ---- Reset with toggling inputs ----
    reset         = 1'b1;
    bus.cnt_en    = 1'b0;
    bus.seq_en    = 1'b1;
    bus.seq_start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.cnt_en    = ~i[0];
      bus.seq_start = 1'b1;
      bus.seq_en    = 1'b1;
      @(negedge sdc_clk);
      chk_idle("in_reset");
    end
    reset         = 1'b0;
    bus.cnt_en    = 1'b0;
    bus.seq_start = 1'b0;
    @(negedge sdc_clk);
    chk_idle("post_reset");

    // ---- Event counter: 64 isolated pulses ----
    for (int k = 1; k <= 64; k++) begin
      bus.cnt_en = 1'b1;
      @(negedge sdc_clk);
      chk("ev_cnt", 32'(bus.cnt), 32'(k));
      chk("ev_strb", 32'(bus.cnt_strb), (k == 64) ? 32'd1 : 32'd0);
      bus.cnt_en = 1'b0;
      @(negedge sdc_clk);
      chk("ev_hold", 32'(bus.cnt), (k == 64) ? 32'd0 : 32'(k));
      chk("ev_hold_strb", 32'(bus.cnt_strb), 32'd0);
    end

    // ---- Event wrap with cnt_en held high ----
    strb_n     = 0;
    bus.cnt_en = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      @(negedge sdc_clk);
      chk("wrap_cnt", 32'(bus.cnt), (i <= 64) ? 32'(i) : 32'(i - 64));
      chk("wrap_strb", 32'(bus.cnt_strb), (i == 64) ? 32'd1 : 32'd0);
      if (i <= 65 && bus.cnt_strb === 1'b1) strb_n++;
    end
    chk("wrap_strb_count", 32'(strb_n), 32'd1);
    bus.cnt_en = 1'b0;

    // ---- Sequence single run ----
    bus.seq_start = 1'b1;
    @(negedge sdc_clk);
    bus.seq_start = 1'b0;
    chk("seq1_cnt", 32'(bus.seq_cnt), 32'd1);
    chk("seq1_busy", 32'(bus.seq_busy), 32'd1);
    for (int i = 2; i <= 62; i++) begin
      @(negedge sdc_clk);
      chk("seq_cnt", 32'(bus.seq_cnt), 32'(i));
      chk("seq_busy", 32'(bus.seq_busy), 32'd1);
      chk("seq_strb_early", 32'(bus.seq_strb), 32'd0);
    end
    @(negedge sdc_clk);
    chk("seq_strb_63", 32'(bus.seq_strb), 32'd1);
    chk("seq_busy_fall", 32'(bus.seq_busy), 32'd0);
    chk("seq_cnt_end", 32'(bus.seq_cnt), 32'd0);
    @(negedge sdc_clk);
    chk("seq_strb_1cyc", 32'(bus.seq_strb), 32'd0);

    // ---- Back-to-back runs, seq_en low for edges 150..154 ----
    strb_n        = 0;
    bus.seq_start = 1'b1;
    for (int c = 1; c <= 400 && strb_n < 4; c++) begin
      @(negedge sdc_clk);
      if (bus.seq_strb === 1'b1 && bus.seq_en === 1'b1) begin
        strb_t[strb_n] = c;
        strb_n++;
      end
      bus.seq_start = (strb_n < 4) ? bus.seq_strb : 1'b0;
      bus.seq_en    = !(c >= 149 && c <= 153);
    end
    bus.seq_start = 1'b0;
    bus.seq_en    = 1'b1;
    chk("b2b_count", 32'(strb_n), 32'd4);
    if (strb_n == 4) begin
      chk("b2b_p1", 32'(strb_t[0]), 32'd63);
      chk("b2b_p2", 32'(strb_t[1] - strb_t[0]), 32'd63);
      chk("b2b_p3_stretched", 32'(strb_t[2] - strb_t[1]), 32'd68);
      chk("b2b_p4", 32'(strb_t[3] - strb_t[2]), 32'd63);
    end
    @(negedge sdc_clk);
    chk("b2b_idle_busy", 32'(bus.seq_busy), 32'd0);
    chk("b2b_idle_strb", 32'(bus.seq_strb), 32'd0);

    // ---- Strobe held while seq_en is low ----
    bus.seq_start = 1'b1;
    @(negedge sdc_clk);
    bus.seq_start = 1'b0;
    repeat (62) @(negedge sdc_clk);
    chk("frz_strb", 32'(bus.seq_strb), 32'd1);
    bus.seq_en = 1'b0;
    repeat (2) begin
      @(negedge sdc_clk);
      chk("frz_strb_hold", 32'(bus.seq_strb), 32'd1);
    end
    bus.seq_en = 1'b1;
    @(negedge sdc_clk);
    chk("frz_strb_drop", 32'(bus.seq_strb), 32'd0);

    // ---- Mid-run start at seq_cnt = 10 ----
    first_t       = 0;
    strb_n        = 0;
    bus.seq_start = 1'b1;
    for (int c = 1; c <= 150; c++) begin
      @(negedge sdc_clk);
      bus.seq_start = (c == 10);
      if (c == 10) chk("mid_cnt10", 32'(bus.seq_cnt), 32'd10);
`ifdef SDC_SEQ_RESTART_EN
      if (c == 11) chk("mid_reload", 32'(bus.seq_cnt), 32'd1);
`else
      if (c == 11) chk("mid_ignore", 32'(bus.seq_cnt), 32'd11);
`endif
      if (bus.seq_strb === 1'b1) begin
        if (strb_n == 0) first_t = c;
        strb_n++;
      end
    end
    chk("mid_strb_count", 32'(strb_n), 32'd1);
`ifdef SDC_SEQ_RESTART_EN
    chk("mid_strb_time", 32'(first_t), 32'd73);
`else
    chk("mid_strb_time", 32'(first_t), 32'd63);
`endif

    // ---- Reset mid-run aborts without a strobe ----
    bus.seq_start = 1'b1;
    bus.cnt_en    = 1'b1;
    @(negedge sdc_clk);
    bus.seq_start = 1'b0;
    repeat (19) @(negedge sdc_clk);
    chk("abort_cnt20", 32'(bus.seq_cnt), 32'd20);
    reset = 1'b1;
    @(negedge sdc_clk);
    chk_idle("abort_reset");
    reset      = 1'b0;
    bus.cnt_en = 1'b0;
    strb_n     = 0;
    for (int c = 1; c <= 70; c++) begin
      @(negedge sdc_clk);
      if (bus.seq_strb === 1'b1 || bus.seq_busy === 1'b1) strb_n++;
    end
    chk("abort_no_strb", 32'(strb_n), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
